// File: rtl/wgt_buf_pkg.sv
// Shared types and limits for the weight ring buffer.
package wgt_buf_pkg;

  localparam int unsigned MinBanks = 2;
  localparam int unsigned MaxBanks = 16;
  localparam int unsigned BankIdxW = $clog2(MaxBanks);

  // Wide enough for any legal bank count; users narrow it to their pointer width.
  typedef logic [BankIdxW-1:0] bank_idx_t;

  localparam int unsigned ErrWrBit = 0;
  localparam int unsigned ErrRdBit = 1;

endpackage

// File: rtl/wgt_bank_sram.sv
// One weight bank: single write port, single read port with a registered read output.
module wgt_bank_sram #(
  parameter int unsigned DATA_WIDTH = 1024,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register is reset so the buffer's read vector comes up as zero; the array is not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/wgt_ring_buffer.sv
// Multi-bank weight ring buffer: a host fills banks tile by tile, the array drains them in order.
module wgt_ring_buffer
  import wgt_buf_pkg::*;
#(
  parameter int unsigned TN         = 128,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned NUM_BANKS  = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [ADDR_WIDTH-1:0]              wr_addr,
  input  logic [TN*8-1:0]                    wr_data,
  input  logic                               wr_commit,
  input  logic                               rd_en,
  input  logic [ADDR_WIDTH-1:0]              rd_addr,
  input  logic                               rd_release,
  output logic                               rd_avail,
  output logic [TN*8-1:0]                    rd_vec,
  output logic                               rd_valid,
  output logic [$clog2(NUM_BANKS+1)-1:0]     full_cnt,
  output logic [1:0]                         err_sticky
);

  localparam int unsigned DW   = TN * 8;
  localparam int unsigned PtrW = $clog2(NUM_BANKS);
  localparam int unsigned CntW = $clog2(NUM_BANKS + 1);

  if (NUM_BANKS < MinBanks || NUM_BANKS > MaxBanks) begin : g_bad_bank_range
    $fatal(1, "wgt_ring_buffer: NUM_BANKS out of range");
  end
  if ((NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_bank_pow2
    $fatal(1, "wgt_ring_buffer: NUM_BANKS must be a power of two");
  end
  if (TN < 1 || ADDR_WIDTH < 1) begin : g_bad_geometry
    $fatal(1, "wgt_ring_buffer: TN and ADDR_WIDTH must be nonzero");
  end

  logic [PtrW-1:0] wp_q, rp_q, rd_sel_q;
  logic [CntW-1:0] cnt_q;
  logic            rd_valid_q;
  logic [1:0]      err_q;

  logic wr_acc, commit, rd_acc, rel;

  always_comb begin
    wr_ready = cnt_q < CntW'(NUM_BANKS);
    rd_avail = cnt_q != '0;
    wr_acc   = wr_valid & wr_ready;
    commit   = wr_acc & wr_commit;
    rd_acc   = rd_en & rd_avail;
    rel      = rd_release & rd_avail;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      rd_sel_q   <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= '0;
    end else begin
      if (commit) wp_q <= wp_q + 1'b1;
      if (rel)    rp_q <= rp_q + 1'b1;
      cnt_q      <= cnt_q + CntW'(commit) - CntW'(rel);
      rd_valid_q <= rd_acc;
      // Remember which bank produced the vector so a later release does not disturb rd_vec.
      if (rd_acc) rd_sel_q <= rp_q;
      if (wr_valid & ~wr_ready)                err_q[ErrWrBit] <= 1'b1;
      if ((rd_en | rd_release) & ~rd_avail)    err_q[ErrRdBit] <= 1'b1;
    end
  end

  logic [DW-1:0] bank_rdata [NUM_BANKS];

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    localparam bank_idx_t BankId = bank_idx_t'(i);
    logic bank_we, bank_re;

    assign bank_we = wr_acc & (wp_q == PtrW'(BankId));
    assign bank_re = rd_acc & (rp_q == PtrW'(BankId));

    wgt_bank_sram #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (bank_we),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (bank_re),
      .raddr (rd_addr),
      .rdata (bank_rdata[i])
    );
  end

  assign rd_vec     = bank_rdata[rd_sel_q];
  assign rd_valid   = rd_valid_q;
  assign full_cnt   = cnt_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_wgt_ring_buffer.sv
// Directed bench for wgt_ring_buffer with a queue-level reference model checked every cycle.
module tb_wgt_ring_buffer;

  localparam int TN    = 128;
  localparam int AW    = 7;
  localparam int NB    = 4;
  localparam int DW    = TN * 8;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = $clog2(NB + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0, wr_commit = 1'b0, rd_en = 1'b0, rd_release = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready, rd_avail, rd_valid;
  logic [DW-1:0] rd_vec;
  logic [CW-1:0] full_cnt;
  logic [1:0]    err_sticky;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  wgt_ring_buffer #(
    .TN         (TN),
    .ADDR_WIDTH (AW),
    .NUM_BANKS  (NB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_commit  (wr_commit),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_release (rd_release),
    .rd_avail   (rd_avail),
    .rd_vec     (rd_vec),
    .rd_valid   (rd_valid),
    .full_cnt   (full_cnt),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h", name,
               act[DW-1 -: 32], act[31:0], exp[DW-1 -: 32], exp[31:0]);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int n, input int a);
    logic [DW-1:0] v;
    v = DW'(n * 256 + a);
    if (n > 0) v[DW-1 -: 16] = 16'(n * 256 + a);
    return v;
  endfunction

  // Reference model: banks as a plain array, FIFO of full tiles tracked by head/tail/count.
  logic [DW-1:0] mm [NB][DEPTH];
  int            m_wp = 0, m_rp = 0, m_cnt = 0;
  logic [1:0]    m_err = '0;
  bit            m_rv = 1'b0;
  logic [DW-1:0] m_vec = '0;

  always @(posedge clk or negedge rst_n) begin : model
    bit wok, rok;
    if (!rst_n) begin
      m_wp = 0; m_rp = 0; m_cnt = 0; m_err = '0; m_rv = 1'b0; m_vec = '0;
    end else begin
      wok  = m_cnt < NB;
      rok  = m_cnt != 0;
      m_rv = rd_en && rok;
      if (m_rv) m_vec = mm[m_rp][rd_addr];
      if ((rd_en || rd_release) && !rok) m_err[1] = 1'b1;
      if (wr_valid) begin
        if (wok) begin
          mm[m_wp][wr_addr] = wr_data;
          if (wr_commit) begin
            m_wp = (m_wp + 1) % NB;
            m_cnt++;
          end
        end else begin
          m_err[0] = 1'b1;
        end
      end
      if (rd_release && rok) begin
        m_rp = (m_rp + 1) % NB;
        m_cnt--;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("wr_ready", DW'(wr_ready), DW'(m_cnt < NB));
      chk("rd_avail", DW'(rd_avail), DW'(m_cnt != 0));
      chk("full_cnt", DW'(full_cnt), DW'(m_cnt));
      chk("err_sticky", DW'(err_sticky), DW'(m_err));
      chk("rd_valid", DW'(rd_valid), DW'(m_rv));
      chk("rd_vec", rd_vec, m_vec);
    end
  end

  // Drive one cycle of inputs at a falling edge, return at the next falling edge.
  task automatic step(input bit wv, input int wa, input logic [DW-1:0] wd, input bit wc,
                      input bit re, input int ra, input bit rel);
    wr_valid   = wv;
    wr_addr    = wa[AW-1:0];
    wr_data    = wd;
    wr_commit  = wc;
    rd_en      = re;
    rd_addr    = ra[AW-1:0];
    rd_release = rel;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic fill(input int tile);
    for (int a = 0; a < DEPTH; a++) step(1, a, pat(tile, a), a == DEPTH - 1, 0, 0, 0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset wr_ready", DW'(wr_ready), DW'(1));
    chk("reset rd_avail", DW'(rd_avail), DW'(0));
    chk("reset full_cnt", DW'(full_cnt), DW'(0));
    chk("reset rd_valid", DW'(rd_valid), DW'(0));
    chk("reset rd_vec", rd_vec, '0);
    cmp_en = 1'b1;

    // Read and release with nothing full.
    step(0, 0, '0, 0, 1, 3, 0);
    chk("empty read rd_valid", DW'(rd_valid), DW'(0));
    chk("empty read err", DW'(err_sticky), DW'(2'b10));
    step(0, 0, '0, 0, 0, 0, 1);
    chk("empty release full_cnt", DW'(full_cnt), DW'(0));

    // First tile, data = addr.
    fill(0);
    chk("tile0 full_cnt", DW'(full_cnt), DW'(1));
    chk("tile0 rd_avail", DW'(rd_avail), DW'(1));
    step(0, 0, '0, 0, 1, 5, 0);
    chk("read addr5 rd_vec", rd_vec, DW'(5));
    chk("read addr5 rd_valid", DW'(rd_valid), DW'(1));
    idle(1);
    chk("hold rd_valid", DW'(rd_valid), DW'(0));
    chk("hold rd_vec", rd_vec, DW'(5));

    // Fill to capacity, then an over-write attempt.
    fill(1); fill(2); fill(3);
    chk("full full_cnt", DW'(full_cnt), DW'(4));
    chk("full wr_ready", DW'(wr_ready), DW'(0));
    step(1, 127, '1, 1, 0, 0, 0);
    chk("drop err", DW'(err_sticky), DW'(2'b11));
    chk("drop full_cnt", DW'(full_cnt), DW'(4));
    step(0, 0, '0, 0, 1, 127, 0);
    chk("bank0 intact", rd_vec, DW'(127));

    // Read with release returns the pre-release bank.
    step(0, 0, '0, 0, 1, 9, 1);
    chk("read+release bank0", rd_vec, DW'(9));
    step(0, 0, '0, 0, 1, 9, 1);
    chk("read+release bank1", rd_vec, pat(1, 9));
    chk("after releases full_cnt", DW'(full_cnt), DW'(2));

    // Commit and release together at full_cnt == 2.
    for (int a = 0; a < DEPTH; a++)
      step(1, a, pat(4, a), a == DEPTH - 1, 0, 0, a == DEPTH - 1);
    chk("commit+release full_cnt", DW'(full_cnt), DW'(2));
    step(0, 0, '0, 0, 1, 3, 0);
    chk("rp advanced to bank3", rd_vec, pat(3, 3));
    step(0, 0, '0, 0, 1, 7, 1);
    step(0, 0, '0, 0, 1, 7, 1);
    chk("wp advanced, bank0 holds tile4", rd_vec, pat(4, 7));
    chk("drained full_cnt", DW'(full_cnt), DW'(0));
    idle(2);

    // Nine fill/consume rounds wrapping both pointers.
    for (int r = 0; r < 9; r++) begin
      fill(5 + r);
      step(0, 0, '0, 0, 1, 0, 0);
      step(0, 0, '0, 0, 1, 64, 0);
      step(0, 0, '0, 0, 1, 127, 1);
      idle(1);
    end
    chk("round13 last read", rd_vec, pat(13, 127));

    // Reset in the middle of a read with three full banks.
    fill(14); fill(15); fill(16);
    chk("pre-reset full_cnt", DW'(full_cnt), DW'(3));
    rd_en   = 1'b1;
    rd_addr = 1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset rd_vec", rd_vec, '0);
    chk("async reset rd_valid", DW'(rd_valid), DW'(0));
    chk("async reset full_cnt", DW'(full_cnt), DW'(0));
    chk("async reset err", DW'(err_sticky), DW'(0));
    rd_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post-reset wr_ready", DW'(wr_ready), DW'(1));
    chk("post-reset rd_avail", DW'(rd_avail), DW'(0));
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wgt_ring_buffer.md
WGT_RING_BUFFER -- requirements
Module: wgt_ring_buffer

Interface
REQ-001 Parameter TN, default 128: weight vector width in INT8 elements.
REQ-002 Parameter ADDR_WIDTH, default 7: per-bank address width; bank depth is 2^ADDR_WIDTH.
REQ-003 Parameter NUM_BANKS, default 4: bank count; power of two, 2..16.
REQ-004 clk  input  1  clock.
REQ-005 rst_n  input  1  reset: asynchronous, active-low.
REQ-006 wr_valid  input  1  host write request.
REQ-007 wr_ready  output  1  a free bank is available to the writer.
REQ-008 wr_addr  input  ADDR_WIDTH  write address within the current write bank.
REQ-009 wr_data  input  TN*8  write vector.
REQ-010 wr_commit  input  1  qualifies the final write of a tile; the write bank becomes FULL.
REQ-011 rd_en  input  1  array read request.
REQ-012 rd_addr  input  ADDR_WIDTH  read address (k index) within the current read bank.
REQ-013 rd_release  input  1  array finished with the current read bank.
REQ-014 rd_avail  output  1  at least one FULL bank exists.
REQ-015 rd_vec  output  TN*8  read vector.
REQ-016 rd_valid  output  1  rd_vec holds data from an accepted read.
REQ-017 full_cnt  output  $clog2(NUM_BANKS+1)  number of FULL banks.
REQ-018 err_sticky  output  2  bit0 = write while !wr_ready; bit1 = rd_en or rd_release while !rd_avail.

Function
REQ-019 Write pointer wp and read pointer rp SHALL be $clog2(NUM_BANKS)-bit and wrap from NUM_BANKS-1 to 0.
REQ-020 wr_ready = (full_cnt < NUM_BANKS); rd_avail = (full_cnt != 0).
REQ-021 Write accepted (wr_valid & wr_ready) SHALL store wr_data at bank[wp][wr_addr] on that clock edge.
REQ-022 Accepted write with wr_commit SHALL store the data, then advance wp by 1 and increment full_cnt in the same edge.
REQ-023 wr_commit without wr_valid SHALL be ignored.
REQ-024 rd_en & rd_avail SHALL read bank[rp][rd_addr]; rd_vec and rd_valid SHALL update on the next edge (latency 1).
REQ-025 Without an accepted read, rd_valid SHALL deassert next cycle and rd_vec SHALL hold its value.
REQ-026 rd_release & rd_avail SHALL advance rp by 1 and decrement full_cnt.
REQ-027 A read and a release in the same cycle SHALL return data from the pre-release bank.
REQ-028 Commit and release in the same cycle SHALL leave full_cnt unchanged and advance both pointers.
REQ-029 Commit while full_cnt == NUM_BANKS-1 SHALL drive wr_ready low the next cycle.
REQ-030 A write or commit while !wr_ready SHALL be dropped (no memory change, no pointer change) and SHALL set err_sticky[0].
REQ-031 rd_en or rd_release while !rd_avail SHALL be ignored and SHALL set err_sticky[1].
REQ-032 When wp == rp and full_cnt == 0, a write to bank wp SHALL not be visible to the reader until the commit.
REQ-033 Reading the bank currently being written is impossible by construction: rp != wp whenever 0 < full_cnt < NUM_BANKS.

Reset
REQ-034 Asserting rst_n low SHALL asynchronously clear wp, rp, full_cnt, rd_valid, rd_vec and err_sticky to 0.
REQ-035 Reset mid-operation SHALL discard all FULL banks; memory contents are not cleared and are undefined to readers.
REQ-036 Release from reset SHALL give wr_ready = 1 and rd_avail = 0 in the first cycle.

Structure
REQ-037 Package wgt_buf_pkg SHALL hold the bank-index typedef, the err_sticky bit-position constants and the parameter-range limits.
REQ-038 One sub-module, wgt_bank_sram (1W1R, registered read), SHALL be instantiated NUM_BANKS times; rd_vec SHALL be muxed from the registered outputs by the rp of the prior cycle.
REQ-039 Parameter-range checks SHALL be elaboration-time assertions; the design SHALL contain no clock gating.

Verification
REQ-040 With NUM_BANKS=4: fill bank0 at addr 0..127 with data=addr and commit at addr 127 -> full_cnt=1, rd_avail=1; read addr 5 -> rd_vec=5 one cycle later.
REQ-041 Commit 4 tiles with no release -> wr_ready=0; a 5th write -> dropped, err_sticky[0]=1, bank0 data intact.
REQ-042 Commit and release in the same cycle at full_cnt=2 -> full_cnt stays 2; wp and rp each advance by 1.
REQ-043 Run 9 fill/consume rounds -> pointers wrap 3->0; each tile reads back its own pattern (tile n, addr a -> n*256+a).
REQ-044 rd_en with full_cnt=0 -> rd_valid stays 0 and err_sticky[1]=1.
REQ-045 Assert rst_n low with full_cnt=3 during a read -> all outputs 0 immediately; wr_ready=1 and rd_avail=0 after release.
